// File: rtl/shift_deser_if.sv
// Receive-side bundle for shift_deser: serial input, realign control and the
// completed-word valid/ready port with its status flags.
interface shift_deser_if #(
  parameter int N = 32
);
  logic         en;
  logic         dir;
  logic         sync;
  logic         sin;
  logic         sin_valid;
  logic [N-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         busy;
  logic         overrun;

  modport master (
    output en, dir, sync, sin, sin_valid, q_ready,
    input  q, q_valid, busy, overrun
  );

  modport slave (
    input  en, dir, sync, sin, sin_valid, q_ready,
    output q, q_valid, busy, overrun
  );
endinterface

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles N-bit words LSB- or MSB-first and
// presents them on a valid/ready output register with sticky overrun.
module shift_deser #(
  parameter int N = 32
) (
  input  logic          i_clk,
  input  logic          i_clr,
  shift_deser_if.slave  io
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0]  r_sh;
  logic [CW-1:0] r_cnt;
  logic          r_dir_l;
  logic [N-1:0]  r_q;
  logic          r_q_valid;
  logic          r_overrun;

  logic          w_take;
  logic          w_order;
  logic          w_last;
  logic          w_complete;
  logic [N-1:0]  w_sh_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_dir_l_nxt;
  logic [N-1:0]  w_q_nxt;
  logic          w_q_valid_nxt;
  logic          w_overrun_nxt;

  assign w_take = io.en && io.sin_valid;
  assign w_last = (r_cnt == CW'(N - 1));

  // Bit order and shift path: a word's first bit (including the one after sync) takes live dir.
  always_comb begin
    w_order  = r_dir_l;
    w_sh_nxt = r_sh;
    if ((r_cnt == {CW{1'b0}}) || io.sync) begin
      w_order = io.dir;
    end else begin
      w_order = r_dir_l;
    end
    if (w_order) begin
      w_sh_nxt = {r_sh[N-2:0], io.sin};
    end else begin
      w_sh_nxt = {io.sin, r_sh[N-1:1]};
    end
  end

  // Bit counter, latched order and word-completion detect; sync overrides the count.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_dir_l_nxt = r_dir_l;
    w_complete  = 1'b0;
    if (w_take && ((r_cnt == {CW{1'b0}}) || io.sync)) begin
      w_dir_l_nxt = io.dir;
    end else begin
      w_dir_l_nxt = r_dir_l;
    end
    if (io.sync) begin
      if (w_take) begin
        w_cnt_nxt = CW'(1);
      end else begin
        w_cnt_nxt = {CW{1'b0}};
      end
    end else if (w_take) begin
      if (w_last) begin
        w_cnt_nxt  = {CW{1'b0}};
        w_complete = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Output register: a completion may land in the same cycle as a handshake (zero bubble).
  always_comb begin
    w_q_nxt       = r_q;
    w_q_valid_nxt = r_q_valid;
    w_overrun_nxt = r_overrun;
    if (w_complete) begin
      if (!r_q_valid || io.q_ready) begin
        w_q_nxt       = w_sh_nxt;
        w_q_valid_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end else if (r_q_valid && io.q_ready) begin
      w_q_valid_nxt = 1'b0;
    end else begin
      w_q_valid_nxt = r_q_valid;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_sh      <= {N{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_dir_l   <= 1'b0;
      r_q       <= {N{1'b0}};
      r_q_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_take) begin
        r_sh <= w_sh_nxt;
      end
      r_cnt     <= w_cnt_nxt;
      r_dir_l   <= w_dir_l_nxt;
      r_q       <= w_q_nxt;
      r_q_valid <= w_q_valid_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign io.q       = r_q;
  assign io.q_valid = r_q_valid;
  assign io.overrun = r_overrun;
  assign io.busy    = (r_cnt != {CW{1'b0}});

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser (N = 8) with a word-level reference model
// compared every cycle, plus literal expectations per scenario.
module tb_shift_deser;
  localparam int N = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  shift_deser_if #(.N(N)) bus ();

  shift_deser #(.N(N)) dut (
    .i_clk (clk),
    .i_clr (clr),
    .io    (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit           m_bits[$];
  bit           m_ord;
  logic [N-1:0] m_q;
  bit           m_qv;
  bit           m_ovr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_ord = 1'b0;
    m_q   = '0;
    m_qv  = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Word-level reference: collect bits, pack by arithmetic once N have arrived.
  task automatic model_step(input bit en, input bit dir, input bit sync,
                            input bit sin, input bit sv, input bit rdy);
    logic [N-1:0] w;
    bit done;
    done = 1'b0;
    w    = '0;
    if (sync) m_bits.delete();
    if (en && sv) begin
      if (m_bits.size() == 0) m_ord = dir;
      m_bits.push_back(sin);
      if (m_bits.size() == N) begin
        done = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (m_ord) w[N-1-i] = m_bits[i];
          else       w[i]     = m_bits[i];
        end
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_qv || rdy) begin
        m_q  = w;
        m_qv = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_qv && rdy) begin
      m_qv = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("q",       bus.q,       m_q);
    chk("q_valid", bus.q_valid, m_qv);
    chk("busy",    bus.busy,    m_bits.size() != 0);
    chk("overrun", bus.overrun, m_ovr);
  endtask

  // One clock: drive after negedge, model at posedge, compare at next negedge.
  task automatic cyc(input bit en, input bit dir, input bit sync,
                     input bit sin, input bit sv, input bit rdy);
    bus.en = en; bus.dir = dir; bus.sync = sync;
    bus.sin = sin; bus.sin_valid = sv; bus.q_ready = rdy;
    @(posedge clk);
    model_step(en, dir, sync, sin, sv, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit d, input bit rdy);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, d, 1'b0, d ? w[N-1-i] : w[i], 1'b1, rdy);
    end
  endtask

  task automatic async_reset();
    #2 clr = 1'b1;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] bits_a;
    logic [N-1:0] wd;
    bits_a = 8'b0100_1101;  // serial order 1,0,1,1,0,0,1,0 read from bit 0 upward
    clr = 1'b1;
    bus.en = 1'b0; bus.dir = 1'b0; bus.sync = 1'b0;
    bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.q_ready = 1'b0;
    model_reset();
    #2 compare_all();
    chk("reset_q", bus.q, 32'h0);
    @(negedge clk);
    clr = 1'b0;

    // LSB-first 1,0,1,1,0,0,1,0
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, bits_a[i], 1'b1, 1'b1);
    chk("lsb_q_lit", bus.q, 32'h4D);
    chk("lsb_qv_lit", bus.q_valid, 32'h1);
    chk("lsb_busy_lit", bus.busy, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lsb_qv_drop_lit", bus.q_valid, 32'h0);

    // MSB-first, dir toggled after the first bit
    for (int i = 0; i < 8; i++) cyc(1'b1, (i == 0) ? 1'b1 : ((i % 2) == 0), 1'b0, bits_a[i], 1'b1, 1'b1);
    chk("msb_q_lit", bus.q, 32'hB2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Gaps: en=0 and sin_valid=0 cycles before every bit
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, ~bits_a[i], 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, ~bits_a[i], 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, bits_a[i], 1'b1, 1'b1);
    end
    chk("gap_q_lit", bus.q, 32'h4D);

    // Sync alone after 3 bits
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sync_busy_lit", bus.busy, 32'h0);
    send_word(8'h96, 1'b0, 1'b1);
    chk("sync_q_lit", bus.q, 32'h96);

    // Sync coinciding with the first bit of the new word
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    wd = 8'h5A;
    cyc(1'b1, 1'b0, 1'b1, wd[0], 1'b1, 1'b1);
    chk("syncbit_busy_lit", bus.busy, 32'h1);
    for (int i = 1; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, wd[i], 1'b1, 1'b1);
    chk("syncbit_q_lit", bus.q, 32'h5A);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: second word dropped
    send_word(8'hA5, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("bp_q_lit", bus.q, 32'hA5);
    chk("bp_ovr_lit", bus.overrun, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_qv_lit", bus.q_valid, 32'h0);
    chk("bp_ovr_sticky_lit", bus.overrun, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    async_reset();
    chk("rst_ovr_lit", bus.overrun, 32'h0);

    // Zero bubble: ready only on the edge completing word 2
    send_word(8'h11, 1'b1, 1'b0);
    wd = 8'hE7;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, wd[7-i], 1'b1, i == 7);
    chk("zb_q_lit", bus.q, 32'hE7);
    chk("zb_qv_lit", bus.q_valid, 32'h1);
    chk("zb_ovr_lit", bus.overrun, 32'h0);

    // Async reset mid-word, then a full word
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    async_reset();
    chk("mid_rst_qv_lit", bus.q_valid, 32'h0);
    chk("mid_rst_busy_lit", bus.busy, 32'h0);
    send_word(8'hC3, 1'b1, 1'b1);
    chk("post_rst_q_lit", bus.q, 32'hC3);
    chk("post_rst_qv_lit", bus.q_valid, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-to-parallel receiver for N-bit words produced by the team's variable shift register when it is used as a serializer. One serial bit is accepted per enabled, valid clock, and bits are assembled in the order set by `dir`: LSB-first for right-shift transmission, MSB-first for left-shift transmission. Completed words are presented on a valid/ready output register with sticky overrun detection. The block sits at the receive end of the serial link, feeding downstream word-wide logic.

## Interface
- `N`, default 32: word width, N ≥ 2.
- `clk`  in  1: rising-edge clock.
- `clr`  in  1: asynchronous reset, active-high. Clears all state immediately.
- `en`  in  1: receive enable. When 0, `sin_valid` is ignored and the partial word is held.
- `dir`  in  1: bit order. 0 = LSB-first (mates with a right-shifting transmitter). 1 = MSB-first (mates with a left-shifting transmitter).
- `sync`  in  1: synchronous frame realign. Discards the partial word.
- `sin`  in  1: serial data bit.
- `sin_valid`  in  1: `sin` carries a bit this cycle.
- `q`  out  N: completed word. Stable while `q_valid` is high.
- `q_valid`  out  1: word available.
- `q_ready`  in  1: consumer accepts `q` in a cycle where `q_valid && q_ready`.
- `busy`  out  1: partial word in progress (bit count ≠ 0).
- `overrun`  out  1: sticky flag. A completed word was dropped.

## Operation
- Internal state:
  - shift register `sh[N-1:0]`
  - bit counter `cnt`, width $clog2(N), range 0..N-1
  - latched order bit `dir_l`
  - output register `q` and flag `q_valid`
- Bit accept: `take = en && sin_valid`.
- `dir_l` is sampled from `dir` when `take && cnt == 0`, including when the bit is the first bit after `sync`. It is held for the rest of the word. `dir` changes mid-word have no effect.
- Shift on `take`, using the effective order (`dir` when `cnt == 0`, else `dir_l`):
  - order 0: `sh <= {sin, sh[N-1:1]}`. The first received bit ends up in `q[0]`.
  - order 1: `sh <= {sh[N-2:0], sin}`. The first received bit ends up in `q[N-1]`.
- Counter: on `take`, `cnt <= (cnt == N-1) ? 0 : cnt + 1`. On wrap, the word is complete. `assembled` denotes the post-shift value of `sh`.
- Completion handling:
  - `q_valid == 0`, or `q_ready == 1` in the same cycle: `q <= assembled`, `q_valid <= 1`.
  - `q_valid == 1 && q_ready == 0`: new word dropped, `q` unchanged, `overrun <= 1`.
- Consumption without completion: `q_valid && q_ready` → `q_valid <= 0`. `q` holds its last value.
- `sync` (takes priority over `take` for counter reset):
  - `sync && !take`: `cnt <= 0`. `sh` contents are don't-care.
  - `sync && take`: the partial word is discarded. The concurrent bit becomes bit 1 of a new word: `cnt <= 1`, `dir_l` sampled from `dir`, shift applied. No completion can occur that cycle.
- `en == 0`: `sh`, `cnt`, `dir_l` hold. Output handshake still operates, so `q_ready` still clears `q_valid`.
- `overrun` clears only on `clr`.
- `busy = (cnt != 0)`, combinational from the register.

## Timing
- Reset (`clr` high, asynchronous): `q = 0`, `q_valid = 0`, `overrun = 0`, `busy = 0`, `sh = 0`, `cnt = 0`, `dir_l = 0`.
  - Assertion mid-word discards the word.
  - Deassertion is synchronous to design intent. The first `take` may occur on the first rising edge after release.
- Throughput: one bit per clock. Back-to-back words with no gap are supported.
- Latency: the edge that accepts bit N of a word sets `q_valid`, and `q` is valid in the following cycle. Total is N accepting edges from the first bit to `q_valid`.
- `q_valid` stays high until the handshake. A handshake coinciding with a completion keeps `q_valid` high with the new `q`: zero-bubble.
- `overrun` rises on the edge of the dropped completion.
- No combinational path from inputs to outputs.

## Test plan
- Bench uses N = 8. In each scenario, stimulus → required response.
- LSB-first: `dir = 0`, send bits 1,0,1,1,0,0,1,0 with `q_ready = 1` → after the 8th accepting edge, `q = 8'h4D`, `q_valid` high for 1 cycle, `busy` back to 0.
- MSB-first with mid-word `dir` toggle: `dir = 1` at the first bit, then toggled, same bits → `q = 8'hB2` (toggle ignored).
- Gaps and sync:
  - insert `en = 0` and `sin_valid = 0` cycles between bits → same `q` as the gap-free case.
  - assert `sync` after 3 bits, then send 8 new bits → only the new word appears.
  - assert `sync` together with a bit → that bit is the new word's first bit.
- Backpressure: `q_ready = 0`, send words A5 then 3C back-to-back → `q = A5` held, `overrun = 1` after the 16th bit. Then `q_ready = 1` for 1 cycle → `q_valid` falls, `overrun` stays 1.
- Zero-bubble: `q_ready` asserted exactly on the edge completing word 2 → `q_valid` stays 1, `q` updates to word 2, `overrun = 0`.
- Async reset: assert `clr` between clock edges after 5 bits → all outputs 0 immediately. The next 8 bits yield a correct full word.
